// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the CPU data-side bus responder.
// Included by the responder top and its byte-lane RAM.
package mem_bus_pkg;

  localparam int WORD_W = 32;
  localparam int BE_W   = 4;
  localparam int CNT_W  = 4;

  localparam logic [BE_W-1:0] BE_WORD = 4'b1111;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACK
  } resp_state_t;

  // What the ACK cycle will do, decided in the last WAIT cycle.
  typedef enum logic [1:0] {
    RESP_NONE,
    RESP_READ,
    RESP_WRITE,
    RESP_FAULT
  } resp_kind_t;

  // The window base is aligned to its size, so only the upper bits need comparing.
  function automatic logic in_window(input logic [31:0] addr,
                                     input logic [31:0] base,
                                     input int unsigned aw);
    return (addr >> aw) == (base >> aw);
  endfunction

endpackage

// File: rtl/byte_lane_ram.sv
// Word-wide RAM with per-byte-lane write enables and a registered read port.
module byte_lane_ram
  import mem_bus_pkg::*;
#(
  parameter int unsigned IDX_W     = 10,
  parameter string       INIT_FILE = ""
) (
  input  logic              clk,
  input  logic [BE_W-1:0]   we,
  input  logic              re,
  input  logic [IDX_W-1:0]  idx,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  localparam int unsigned DEPTH = 1 << IDX_W;

  logic [WORD_W-1:0] mem [DEPTH];

  // NOTE: the array and its read register have no reset; contents must survive
  // rst_n, and a reset would also stop the array mapping onto RAM macros.
  always_ff @(posedge clk) begin
    for (int i = 0; i < BE_W; i++) begin
      if (we[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
    end
    if (re) rdata <= mem[idx];
  end

endmodule

// File: rtl/data_mem_responder.sv
// Avalon-MM style data-memory responder: stretches each request with a fixed
// number of wait states, then commits byte-lane writes or returns read data.
module data_mem_responder
  import mem_bus_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 12,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_1000,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter string       INIT_FILE   = ""
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       address,
  input  logic              read,
  input  logic              write,
  input  logic [BE_W-1:0]   byteenable,
  input  logic [WORD_W-1:0] writedata,
  output logic [WORD_W-1:0] readdata,
  output logic              waitrequest,
  output logic              fault
);

  localparam int unsigned IDX_W = ADDR_WIDTH - 2;

  resp_state_t       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  resp_kind_t        kind_q, kind_d;
  logic              zero_rd_q, zero_rd_d;

  logic              req;
  logic              in_win;
  logic              legal_rd;
  logic              legal_wr;
  logic              ram_re;
  logic [BE_W-1:0]   ram_we;
  logic [IDX_W-1:0]  word_idx;
  logic [WORD_W-1:0] ram_rdata;

  assign req      = read | write;
  assign in_win   = in_window(address, BASE_ADDR, ADDR_WIDTH);
  assign legal_rd = read & ~write & in_win;
  assign legal_wr = write & ~read & in_win;
  assign word_idx = address[ADDR_WIDTH-1:2];

  // NOTE: every signal driven here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    kind_d      = kind_q;
    zero_rd_d   = zero_rd_q;
    ram_re      = 1'b0;
    waitrequest = 1'b0;

    case (state_q)
      IDLE: begin
        waitrequest = req;
        if (req) begin
          cnt_d   = CNT_W'(WAIT_CYCLES);
          state_d = WAIT;
        end
      end

      WAIT: begin
        waitrequest = 1'b1;
        if (!req) begin
          // CPU withdrew the request: abandon it without touching memory or readdata.
          cnt_d   = '0;
          state_d = IDLE;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          ram_re    = legal_rd;
          zero_rd_d = ~legal_rd;
          kind_d    = legal_rd ? RESP_READ  :
                      legal_wr ? RESP_WRITE : RESP_FAULT;
          state_d   = ACK;
        end
      end

      ACK: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      kind_q    <= RESP_NONE;
      zero_rd_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      kind_q    <= kind_d;
      zero_rd_q <= zero_rd_d;
    end
  end

  // Write data and lanes are taken in the ACK cycle; an aborting reset forces
  // the state out of ACK before the commit edge.
  assign ram_we = (state_q == ACK && kind_q == RESP_WRITE) ? (byteenable & BE_WORD) : '0;

  assign readdata = zero_rd_q ? '0 : ram_rdata;
  assign fault    = (state_q == ACK) && (kind_q == RESP_FAULT);

  byte_lane_ram #(
    .IDX_W     (IDX_W),
    .INIT_FILE (INIT_FILE)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .re    (ram_re),
    .idx   (word_idx),
    .wdata (writedata),
    .rdata (ram_rdata)
  );

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench: three responders (2, 0 and 15 wait states) driven by
// directed and random transfers, compared every cycle against a word-level model.
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rd   [3];
  logic        wr   [3];
  logic [31:0] addr [3];
  logic [31:0] wd   [3];
  logic [3:0]  be   [3];
  logic [31:0] rdat [3];
  logic        wreq [3];
  logic        flt  [3];

  int checks   = 0;
  int failures = 0;

  // Per-cycle expectations, written by the stimulus, read by the compare process.
  bit          exp_wreq [3];
  bit          exp_flt  [3];
  bit          chk_rd   [3];
  logic [31:0] exp_rd   [3];
  logic [31:0] last_rd  [3];
  bit          last_ok  [3];
  int          hi_cnt   [3];

  // Model memory keyed by dut*1024 + word index; absent key means unknown.
  bit [31:0] mem_m [int unsigned];

  logic [31:0] got;
  logic        gotf;
  int          hi;

  always #5 clk = ~clk;

  data_mem_responder #(.WAIT_CYCLES(2)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .address(addr[0]), .read(rd[0]), .write(wr[0]),
    .byteenable(be[0]), .writedata(wd[0]), .readdata(rdat[0]),
    .waitrequest(wreq[0]), .fault(flt[0]));

  data_mem_responder #(.WAIT_CYCLES(0)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .address(addr[1]), .read(rd[1]), .write(wr[1]),
    .byteenable(be[1]), .writedata(wd[1]), .readdata(rdat[1]),
    .waitrequest(wreq[1]), .fault(flt[1]));

  data_mem_responder #(.WAIT_CYCLES(15)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .address(addr[2]), .read(rd[2]), .write(wr[2]),
    .byteenable(be[2]), .writedata(wd[2]), .readdata(rdat[2]),
    .waitrequest(wreq[2]), .fault(flt[2]));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int wc_of(input int d);
    return (d == 0) ? 2 : (d == 1) ? 0 : 15;
  endfunction

  function automatic bit legal_of(input bit r, input bit w, input logic [31:0] a);
    return (r ^ w) && (a[31:12] == 20'h00001);
  endfunction

  // Compare process: every cycle, away from the rising edge.
  always @(negedge clk) begin
    #2;
    for (int d = 0; d < 3; d++) begin
      if (wreq[d]) hi_cnt[d]++;
      check($sformatf("waitrequest[%0d]", d), {31'b0, wreq[d]}, {31'b0, exp_wreq[d]});
      check($sformatf("fault[%0d]", d), {31'b0, flt[d]}, {31'b0, exp_flt[d]});
      if (chk_rd[d]) check($sformatf("readdata[%0d]", d), rdat[d], exp_rd[d]);
    end
  end

  task automatic set_idle_exp(input int e);
    rd[e]       = 1'b0;
    wr[e]       = 1'b0;
    exp_wreq[e] = 1'b0;
    exp_flt[e]  = 1'b0;
    chk_rd[e]   = last_ok[e];
    exp_rd[e]   = last_rd[e];
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      for (int e = 0; e < 3; e++) set_idle_exp(e);
    end
  endtask

  // One complete transfer; request cycle 0 is the first cycle it is driven.
  task automatic xfer(input int d, input bit r, input bit w, input logic [31:0] a,
                      input logic [31:0] dat, input logic [3:0] b,
                      output logic [31:0] rdv, output logic fv, output int high);
    int          wc;
    int          base;
    bit          legal;
    int unsigned key;
    bit [31:0]   v;
    wc    = wc_of(d);
    legal = legal_of(r, w, a);
    key   = unsigned'(d) * 1024 + a[11:2];
    base  = 0;
    for (int k = 0; k < wc + 3; k++) begin
      @(negedge clk);
      for (int e = 0; e < 3; e++) set_idle_exp(e);
      rd[d] = r; wr[d] = w; addr[d] = a; wd[d] = dat; be[d] = b;
      if (k == 0) base = hi_cnt[d];
      if (k == wc + 2) begin
        exp_wreq[d] = 1'b0;
        exp_flt[d]  = !legal;
        if (!legal) begin
          chk_rd[d] = 1'b1; exp_rd[d] = '0;
        end else if (r && mem_m.exists(key)) begin
          chk_rd[d] = 1'b1; exp_rd[d] = mem_m[key];
        end else begin
          chk_rd[d] = 1'b0;
        end
      end else begin
        exp_wreq[d] = 1'b1;
      end
    end
    #3;
    rdv = rdat[d];
    fv  = flt[d];
    @(posedge clk);
    #1;
    high       = hi_cnt[d] - base;
    last_ok[d] = chk_rd[d];
    last_rd[d] = exp_rd[d];
    if (legal && w) begin
      if (mem_m.exists(key)) begin
        v = mem_m[key];
        for (int i = 0; i < 4; i++) if (b[i]) v[8*i +: 8] = dat[8*i +: 8];
        mem_m[key] = v;
      end else if (b == 4'hF) begin
        mem_m[key] = dat;
      end
    end
  endtask

  // Request held for n cycles (1..WAIT_CYCLES+1), then both strobes dropped in WAIT.
  task automatic abort_xfer(input int d, input bit w, input logic [31:0] a,
                            input logic [31:0] dat, input int n);
    for (int k = 0; k <= n; k++) begin
      @(negedge clk);
      for (int e = 0; e < 3; e++) set_idle_exp(e);
      if (k < n) begin
        rd[d] = !w; wr[d] = w; addr[d] = a; wd[d] = dat; be[d] = 4'hF;
      end
      exp_wreq[d] = 1'b1;
    end
  endtask

  // Write held for n cycles (1..WAIT_CYCLES+2), then rst_n pulled low mid-transfer.
  task automatic reset_xfer(input int d, input logic [31:0] a, input logic [31:0] dat,
                            input int n);
    for (int k = 0; k <= n + 1; k++) begin
      @(negedge clk);
      for (int e = 0; e < 3; e++) set_idle_exp(e);
      if (k <= n) begin
        wr[d] = 1'b1; addr[d] = a; wd[d] = dat; be[d] = 4'hF;
      end
      if (k < n) begin
        exp_wreq[d] = 1'b1;
      end else if (k == n) begin
        rst_n = 1'b0;
        for (int e = 0; e < 3; e++) begin
          last_rd[e] = '0; last_ok[e] = 1'b1; chk_rd[e] = 1'b1; exp_rd[e] = '0;
        end
        exp_wreq[d] = 1'b1;
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int e = 0; e < 3; e++) set_idle_exp(e);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int          d;
    int          op;
    bit          w;
    logic [31:0] a;

    rst_n = 1'b0;
    for (int e = 0; e < 3; e++) begin
      hi_cnt[e] = 0; last_rd[e] = '0; last_ok[e] = 1'b1;
      addr[e] = '0; wd[e] = '0; be[e] = '0;
      set_idle_exp(e);
    end

    // Under reset waitrequest still follows read|write.
    @(negedge clk);
    rd[0] = 1'b1; exp_wreq[0] = 1'b1;
    @(negedge clk);
    for (int e = 0; e < 3; e++) set_idle_exp(e);
    rst_n = 1'b1;
    idle(2);

    // Plain read after preload; high for cycles 0..WAIT_CYCLES+1 inclusive.
    xfer(0, 0, 1, 32'h0000_1000, 32'hDEAD_BEEF, 4'hF, got, gotf, hi);
    idle(1);
    xfer(0, 1, 0, 32'h0000_1000, 32'h0, 4'h0, got, gotf, hi);
    check("lit_read_data", got, 32'hDEAD_BEEF);
    check("lit_read_fault", {31'b0, gotf}, 32'd0);
    check("lit_wait_high_wc2", hi, 32'd4);

    // Partial write over a full word.
    xfer(0, 0, 1, 32'h0000_1004, 32'hAAAA_AAAA, 4'hF, got, gotf, hi);
    xfer(0, 0, 1, 32'h0000_1004, 32'h1122_3344, 4'b0101, got, gotf, hi);
    xfer(0, 1, 0, 32'h0000_1004, 32'h0, 4'h0, got, gotf, hi);
    check("lit_partial_write", got, 32'hAA22_AA44);

    // Out of window, both strobes, empty byteenable.
    xfer(0, 1, 0, 32'h0000_2000, 32'h0, 4'hF, got, gotf, hi);
    check("lit_oow_data", got, 32'h0);
    check("lit_oow_fault", {31'b0, gotf}, 32'd1);
    idle(1);
    xfer(0, 1, 1, 32'h0000_1000, 32'hFFFF_FFFF, 4'hF, got, gotf, hi);
    check("lit_both_fault", {31'b0, gotf}, 32'd1);
    xfer(0, 0, 1, 32'h0000_1000, 32'h0, 4'h0, got, gotf, hi);
    check("lit_be0_fault", {31'b0, gotf}, 32'd0);
    xfer(0, 1, 0, 32'h0000_1000, 32'h0, 4'h0, got, gotf, hi);
    check("lit_mem_unchanged", got, 32'hDEAD_BEEF);

    // Wait-state sweep.
    xfer(1, 1, 0, 32'h0000_1000, 32'h0, 4'hF, got, gotf, hi);
    check("lit_wait_high_wc0", hi, 32'd2);
    idle(1);
    xfer(2, 1, 0, 32'h0000_1000, 32'h0, 4'hF, got, gotf, hi);
    check("lit_wait_high_wc15", hi, 32'd17);
    idle(1);

    // Back-to-back read, write, read of one word.
    xfer(0, 0, 1, 32'h0000_1008, 32'h1234_5678, 4'hF, got, gotf, hi);
    idle(1);
    xfer(0, 1, 0, 32'h0000_1008, 32'h0, 4'hF, got, gotf, hi);
    check("lit_b2b_first", got, 32'h1234_5678);
    xfer(0, 0, 1, 32'h0000_1008, 32'hCAFE_F00D, 4'hF, got, gotf, hi);
    check("lit_b2b_write_high", hi, 32'd4);
    xfer(0, 1, 0, 32'h0000_1008, 32'h0, 4'hF, got, gotf, hi);
    check("lit_b2b_second", got, 32'hCAFE_F00D);
    check("lit_b2b_read_high", hi, 32'd4);

    // Withdrawn request and reset mid-write leave memory alone.
    idle(1);
    abort_xfer(0, 1'b1, 32'h0000_1004, 32'h0BAD_0BAD, 2);
    idle(1);
    reset_xfer(0, 32'h0000_1004, 32'h5555_5555, 2);
    idle(2);
    xfer(0, 1, 0, 32'h0000_1004, 32'h0, 4'hF, got, gotf, hi);
    check("lit_reset_no_commit", got, 32'hAA22_AA44);
    idle(1);

    // Known contents for the random phase.
    for (int e = 0; e < 3; e++) begin
      for (int i = 0; i < 8; i++) begin
        xfer(e, 0, 1, 32'h0000_1000 + 32'(4 * i), $urandom, 4'hF, got, gotf, hi);
      end
      idle(1);
    end

    for (int n = 0; n < 150; n++) begin
      d  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 2)) : 0;
      op = $urandom_range(0, 19);
      w  = $urandom_range(0, 1);
      a  = 32'h0000_1000 + 32'($urandom_range(0, 31));
      if (op == 0) begin
        xfer(d, 1, 1, a, $urandom, 4'($urandom), got, gotf, hi);
      end else if (op == 1) begin
        abort_xfer(d, w, a, $urandom, $urandom_range(1, wc_of(d) + 1));
        idle(1);
      end else if (op == 2) begin
        reset_xfer(d, a, $urandom, $urandom_range(1, wc_of(d) + 2));
        idle(1);
      end else if (op == 3) begin
        a = $urandom;
        if (a[31:12] == 20'h00001) a[31] = 1'b1;
        xfer(d, !w, w, a, $urandom, 4'($urandom), got, gotf, hi);
      end else begin
        xfer(d, !w, w, a, $urandom, 4'($urandom), got, gotf, hi);
      end
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
    end

    idle(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
